// File: rtl/s2mm_stream_arbiter_if.sv
// s2mm_stream_arbiter_if: AXI-Stream bundle shared by the producers
// and the DMA S2MM side of the arbiter.
interface s2mm_stream_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/s2mm_stream_arbiter.sv
// s2mm_stream_arbiter: packet round-robin of two AXI-Stream producers
// onto the DMA S2MM port. Optional counters: S2MM_ARB_STATS_EN.
module s2mm_stream_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 128,
  parameter int BEAT_W    = 8
) (
  input  logic                  FCLK_CLK0,
  input  logic                  FCLK_RESET0_N,
  input  logic                  arb_en,
  input  logic                  err_clr,
  s2mm_stream_arbiter_if.slave  s0,
  s2mm_stream_arbiter_if.slave  s1,
  s2mm_stream_arbiter_if.master m,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  pkt_done,
  output logic                  ovf_err
`ifdef S2MM_ARB_STATS_EN
  ,
  output logic [15:0]           pkt_cnt0,
  output logic [15:0]           pkt_cnt1
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [BEAT_W-1:0] LAST_BEAT =
    BEAT_W'(MAX_BEATS - 1);

  logic [1:0]          state;
  logic                last_grant;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [1:0]          pick;

  logic [DATA_W-1:0]   s_tdata;
  logic [DATA_W/8-1:0] s_tkeep;
  logic                s_tlast;
  logic                s_tvalid;

  logic                at_max;
  logic                hs;
  logic                ovf_set;
  logic                drain_end;

  // Select the owning producer; grant is stable for a whole packet
  always_comb begin
    s_tdata  = grant[1] ? s1.tdata  : s0.tdata;
    s_tkeep  = grant[1] ? s1.tkeep  : s0.tkeep;
    s_tlast  = grant[1] ? s1.tlast  : s0.tlast;
    s_tvalid = grant[1] ? s1.tvalid : s0.tvalid;
  end

  assign at_max    = (beat_cnt == LAST_BEAT);
  assign hs        = (state == ST_PASS) && s_tvalid && m.tready;
  assign pkt_done  = hs && (s_tlast || at_max);
  assign ovf_set   = hs && !s_tlast && at_max;
  assign drain_end = (state == ST_DRAIN) && s_tvalid && s_tlast;
  assign busy      = (state != ST_IDLE);

  // Round-robin pick: a tie goes to the source that did not go last
  always_comb begin
    pick = 2'b00;
    unique case (1'b1)
      s0.tvalid && s1.tvalid:  pick = last_grant ? 2'b01 : 2'b10;
      s0.tvalid && !s1.tvalid: pick = 2'b01;
      !s0.tvalid && s1.tvalid: pick = 2'b10;
      default:                 pick = 2'b00;
    endcase
  end

  // Output steering: pass-through in PASS, swallow beats in DRAIN
  always_comb begin
    m.tdata   = '0;
    m.tkeep   = '0;
    m.tlast   = 1'b0;
    m.tvalid  = 1'b0;
    s0.tready = 1'b0;
    s1.tready = 1'b0;
    case (state)
      ST_PASS: begin
        m.tdata   = s_tdata;
        m.tkeep   = s_tkeep;
        m.tvalid  = s_tvalid;
        m.tlast   = s_tlast || at_max;
        s0.tready = grant[0] && m.tready;
        s1.tready = grant[1] && m.tready;
      end
      ST_DRAIN: begin
        s0.tready = grant[0];
        s1.tready = grant[1];
      end
      default: ;
    endcase
  end

  // Packet FSM: grant on request, hold to tlast, drain oversize tails
  always_ff @(posedge FCLK_CLK0 or negedge FCLK_RESET0_N) begin
    if (!FCLK_RESET0_N) begin
      state      <= ST_IDLE;
      grant      <= 2'b00;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_en && (pick != 2'b00)) begin
            grant <= pick;
            state <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (hs) begin
            if (s_tlast) begin
              last_grant <= grant[1];
              beat_cnt   <= '0;
              grant      <= 2'b00;
              state      <= ST_IDLE;
            end else if (at_max) begin
              state <= ST_DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_end) begin
            last_grant <= grant[1];
            beat_cnt   <= '0;
            grant      <= 2'b00;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear
  always_ff @(posedge FCLK_CLK0 or negedge FCLK_RESET0_N) begin
    if (!FCLK_RESET0_N) begin
      ovf_err <= 1'b0;
    end else if (ovf_set) begin
      ovf_err <= 1'b1;
    end else if (err_clr) begin
      ovf_err <= 1'b0;
    end
  end

`ifdef S2MM_ARB_STATS_EN
  // Saturating per-source completed-packet counters
  always_ff @(posedge FCLK_CLK0 or negedge FCLK_RESET0_N) begin
    if (!FCLK_RESET0_N) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (err_clr) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (pkt_done) begin
      if (grant[0] && (pkt_cnt0 != 16'hFFFF))
        pkt_cnt0 <= pkt_cnt0 + 16'd1;
      if (grant[1] && (pkt_cnt1 != 16'hFFFF))
        pkt_cnt1 <= pkt_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_s2mm_stream_arbiter.sv
// tb_s2mm_stream_arbiter: directed bench for the S2MM
// packet arbiter.
module tb_s2mm_stream_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arb_en;
  logic       err_clr;
  logic [1:0] grant;
  logic       busy;
  logic       pkt_done;
  logic       ovf_err;
`ifdef S2MM_ARB_STATS_EN
  logic [15:0] pkt_cnt0;
  logic [15:0] pkt_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  s2mm_stream_arbiter_if #(.DATA_W(32)) s0_if ();
  s2mm_stream_arbiter_if #(.DATA_W(32)) s1_if ();
  s2mm_stream_arbiter_if #(.DATA_W(32)) m_if ();

  s2mm_stream_arbiter #(
    .DATA_W(32),
    .MAX_BEATS(128),
    .BEAT_W(8)
  ) dut (
    .FCLK_CLK0    (clk),
    .FCLK_RESET0_N(rst_n),
    .arb_en       (arb_en),
    .err_clr      (err_clr),
    .s0           (s0_if),
    .s1           (s1_if),
    .m            (m_if),
    .grant        (grant),
    .busy         (busy),
    .pkt_done     (pkt_done),
    .ovf_err      (ovf_err)
`ifdef S2MM_ARB_STATS_EN
    ,
    .pkt_cnt0     (pkt_cnt0),
    .pkt_cnt1     (pkt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int src,
                                      input int p,
                                      input int b);
    logic [31:0] base;
    base = (src != 0) ? 32'hB000_0000 : 32'hA000_0000;
    return base | (32'(p) << 4) | 32'(b);
  endfunction

  task automatic drv(input int src, input logic v,
                     input logic [31:0] d, input logic l);
    if (src == 0) begin
      s0_if.tvalid = v;
      s0_if.tdata  = d;
      s0_if.tlast  = l;
      s0_if.tkeep  = 4'hF;
    end else begin
      s1_if.tvalid = v;
      s1_if.tdata  = d;
      s1_if.tlast  = l;
      s1_if.tkeep  = 4'h3;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // n-beat packet from one source, m_tready held high
  task automatic send_pkt(input int src, input int n,
                          input int p);
    logic [1:0] oh;
    oh = (src != 0) ? 2'b10 : 2'b01;
    drv(src, 1'b1, dat(src, p, 0), n == 1);
    @(negedge clk);
    chk("pkt_idle_grant", 64'(grant), 64'd0);
    chk("pkt_idle_tvalid", 64'(m_if.tvalid), 64'd0);
    step();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("pkt_grant", 64'(grant), 64'(oh));
      chk("pkt_tvalid", 64'(m_if.tvalid), 64'd1);
      chk("pkt_tdata", 64'(m_if.tdata),
          64'(dat(src, p, i)));
      chk("pkt_tkeep", 64'(m_if.tkeep),
          (src != 0) ? 64'h3 : 64'hF);
      chk("pkt_tlast", 64'(m_if.tlast),
          64'(i == n - 1));
      chk("pkt_done", 64'(pkt_done), 64'(i == n - 1));
      chk("pkt_other_rdy",
          64'((src != 0) ? s0_if.tready : s1_if.tready),
          64'd0);
      step();
      if (i < n - 1)
        drv(src, 1'b1, dat(src, p, i + 1), i + 1 == n - 1);
      else
        drv(src, 1'b0, 32'd0, 1'b0);
    end
    @(negedge clk);
    chk("pkt_end_grant", 64'(grant), 64'd0);
    chk("pkt_end_busy", 64'(busy), 64'd0);
    step();
  endtask

  int  s0_b, s0_p, s1_b, s1_p;
  logic hs0, hs1;

  // Both producers stream 2-beat packets back to back
  task automatic adv();
    hs0 = s0_if.tvalid & s0_if.tready;
    hs1 = s1_if.tvalid & s1_if.tready;
    step();
    if (hs0) begin
      if (s0_b == 1) begin s0_b = 0; s0_p++; end
      else s0_b = 1;
    end
    if (hs1) begin
      if (s1_b == 1) begin s1_b = 0; s1_p++; end
      else s1_b = 1;
    end
    drv(0, 1'b1, dat(0, s0_p, s0_b), s0_b == 1);
    drv(1, 1'b1, dat(1, s1_p, s1_b), s1_b == 1);
  endtask

  initial begin
    logic pat [6];
    int   eb;
    int   tl_seen;
    int   src;
    int   k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    rst_n   = 1'b0;
    arb_en  = 1'b0;
    err_clr = 1'b0;
    m_if.tready = 1'b1;
    drv(0, 1'b0, 32'd0, 1'b0);
    drv(1, 1'b0, 32'd0, 1'b0);

    // reset state
    step();
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(pkt_done), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst_rdy0", 64'(s0_if.tready), 64'd0);
    chk("rst_rdy1", 64'(s1_if.tready), 64'd0);
    step();
    rst_n  = 1'b1;
    arb_en = 1'b1;
    step();

    // basic 4-beat, single-beat, exact-max packets
    send_pkt(0, 4, 1);
    send_pkt(1, 1, 2);
    send_pkt(0, 128, 3);
    @(negedge clk);
    chk("max_no_ovf", 64'(ovf_err), 64'd0);
    step();

    // oversize s1 packet: forced tlast, drain, set beats clear
    tl_seen = 0;
    drv(1, 1'b1, 32'h3000_0000, 1'b0);
    @(negedge clk);
    step();
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (i < 127) tl_seen += int'(m_if.tlast);
      if (i == 127) begin
        chk("ovf_tlast", 64'(m_if.tlast), 64'd1);
        chk("ovf_done", 64'(pkt_done), 64'd1);
        chk("ovf_tdata", 64'(m_if.tdata),
            64'h3000_007F);
        chk("ovf_pre", 64'(ovf_err), 64'd0);
      end
      if (i >= 128) begin
        chk("drn_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("drn_rdy1", 64'(s1_if.tready), 64'd1);
        chk("drn_busy", 64'(busy), 64'd1);
        chk("drn_ovf", 64'(ovf_err), 64'd1);
        chk("drn_done", 64'(pkt_done), 64'd0);
      end
      step();
      err_clr = (i == 126);
      if (i < 129)
        drv(1, 1'b1, 32'h3000_0000 + 32'(i + 1),
            i + 1 == 129);
      else
        drv(1, 1'b0, 32'd0, 1'b0);
    end
    chk("ovf_early_tlast", 64'(tl_seen), 64'd0);
    @(negedge clk);
    chk("ovf_idle_grant", 64'(grant), 64'd0);
    chk("ovf_idle_busy", 64'(busy), 64'd0);
    chk("ovf_sticky", 64'(ovf_err), 64'd1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clear", 64'(ovf_err), 64'd0);
    step();

    // round robin with both producers always valid
    do_reset();
    s0_b = 0; s0_p = 0; s1_b = 0; s1_p = 0;
    drv(0, 1'b1, dat(0, 0, 0), 1'b0);
    drv(1, 1'b1, dat(1, 0, 0), 1'b0);
    for (int p = 0; p < 4; p++) begin
      src = p % 2;
      k   = p / 2;
      @(negedge clk);
      chk("rr_idle_grant", 64'(grant), 64'd0);
      chk("rr_idle_tvalid", 64'(m_if.tvalid), 64'd0);
      adv();
      for (int b = 0; b < 2; b++) begin
        @(negedge clk);
        chk("rr_grant", 64'(grant),
            (src != 0) ? 64'd2 : 64'd1);
        chk("rr_tdata", 64'(m_if.tdata),
            64'(dat(src, k, b)));
        chk("rr_tlast", 64'(m_if.tlast), 64'(b == 1));
        adv();
      end
    end
    drv(0, 1'b0, 32'd0, 1'b0);
    drv(1, 1'b0, 32'd0, 1'b0);
    step();

    // backpressure on m_tready: 1,0,0,1,...
    eb = 0;
    drv(0, 1'b1, dat(0, 9, 0), 1'b0);
    @(negedge clk);
    step();
    for (int c = 0; c < 6; c++) begin
      m_if.tready = pat[c];
      @(negedge clk);
      chk("bp_grant", 64'(grant), 64'd1);
      chk("bp_tvalid", 64'(m_if.tvalid), 64'd1);
      chk("bp_tdata", 64'(m_if.tdata), 64'(dat(0, 9, eb)));
      chk("bp_tlast", 64'(m_if.tlast), 64'(eb == 3));
      chk("bp_rdy0", 64'(s0_if.tready), 64'(pat[c]));
      chk("bp_done", 64'(pkt_done),
          64'((eb == 3) && pat[c]));
      step();
      if (pat[c]) eb++;
      if (eb < 4)
        drv(0, 1'b1, dat(0, 9, eb), eb == 3);
      else
        drv(0, 1'b0, 32'd0, 1'b0);
    end
    m_if.tready = 1'b1;
    @(negedge clk);
    chk("bp_end_grant", 64'(grant), 64'd0);
    step();

    // arb_en drops mid-packet while s1 waits
    drv(0, 1'b1, dat(0, 5, 0), 1'b0);
    @(negedge clk);
    step();
    drv(1, 1'b1, dat(1, 5, 0), 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("en_grant", 64'(grant), 64'd1);
      chk("en_tdata", 64'(m_if.tdata), 64'(dat(0, 5, i)));
      chk("en_done", 64'(pkt_done), 64'(i == 3));
      step();
      if (i == 1) arb_en = 1'b0;
      if (i < 3)
        drv(0, 1'b1, dat(0, 5, i + 1), i + 1 == 3);
      else
        drv(0, 1'b0, 32'd0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dis_grant", 64'(grant), 64'd0);
      chk("dis_rdy1", 64'(s1_if.tready), 64'd0);
      chk("dis_busy", 64'(busy), 64'd0);
      step();
    end
    arb_en = 1'b1;
    @(negedge clk);
    chk("reen_idle", 64'(grant), 64'd0);
    step();
    @(negedge clk);
    chk("reen_grant", 64'(grant), 64'd2);
    chk("reen_tdata", 64'(m_if.tdata), 64'(dat(1, 5, 0)));
    chk("reen_tlast", 64'(m_if.tlast), 64'd1);
    chk("reen_done", 64'(pkt_done), 64'd1);
    step();
    drv(1, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("reen_end", 64'(grant), 64'd0);
    step();

    // async reset in the middle of an s1 packet
    drv(1, 1'b1, dat(1, 6, 0), 1'b0);
    @(negedge clk);
    step();
    @(negedge clk);
    chk("ar_grant_pre", 64'(grant), 64'd2);
    step();
    drv(1, 1'b1, dat(1, 6, 1), 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_grant", 64'(grant), 64'd0);
    chk("ar_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_rdy1", 64'(s1_if.tready), 64'd0);
    drv(1, 1'b0, 32'd0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    send_pkt(1, 3, 7);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
